// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared widths, the PC alignment mask and the fetch state encoding used by
// the program-counter / instruction-fetch slice.
// Ports: none (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned PC_WIDTH    = 64;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned CNT_WIDTH   = 32;

  // Clears the two byte-offset bits of a 4-byte aligned instruction address.
  localparam logic [PC_WIDTH-1:0] PC_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

  // Explicit 2-bit encoding keeps the state vector stable for legacy tooling.
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2,
    ST_FAULT   = 2'd3
  } fetch_state_e;

  // True when the address has any bit set outside the alignment mask.
  function automatic logic pc_misaligned(input logic [PC_WIDTH-1:0] pc);
    return |(pc & ~PC_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_if
// Bundles the instruction-memory request/response channel, the decode
// handshake, the next-PC input and the status outputs of pc_fetch_unit.
// Modports:
//   master - the fetch unit (drives requests, Instr, status)
//   slave  - the environment (memory, decode, next-PC logic)
// ----------------------------------------------------------------------------
interface pc_fetch_unit_if;
  import cpu_pkg::*;

  logic [PC_WIDTH-1:0]    NextPC;
  logic                   IMemReqValid;
  logic                   IMemReqReady;
  logic [PC_WIDTH-1:0]    IMemAddr;
  logic                   IMemRspValid;
  logic [INSTR_WIDTH-1:0] IMemRspData;
  logic                   InstrValid;
  logic                   InstrReady;
  logic [INSTR_WIDTH-1:0] Instr;
  logic [PC_WIDTH-1:0]    CurrentPC;
  logic                   FetchFault;
  logic [CNT_WIDTH-1:0]   InstrCount;

  modport master (
    input  NextPC, IMemReqReady, IMemRspValid, IMemRspData, InstrReady,
    output IMemReqValid, IMemAddr, InstrValid, Instr, CurrentPC,
           FetchFault, InstrCount
  );

  modport slave (
    output NextPC, IMemReqReady, IMemRspValid, IMemRspData, InstrReady,
    input  IMemReqValid, IMemAddr, InstrValid, Instr, CurrentPC,
           FetchFault, InstrCount
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// ----------------------------------------------------------------------------
// fetch_timeout_ctr
// Saturating up-counter with synchronous clear and count enable. tc_o is a
// registered flag that is high while the count equals MAX.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr_i     - reset the count to zero (wins over en_i)
//   en_i      - increment, holding at MAX
//   tc_o      - count == MAX
// ----------------------------------------------------------------------------
module fetch_timeout_ctr #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] count_q, count_d;
  logic         tc_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != W'(MAX))) begin
      count_d = count_q + W'(1);
    end
  end

  // Terminal count is registered alongside the count so it needs no decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= (MAX == 0);
    end else begin
      count_q <= count_d;
      tc_q    <= (count_d == W'(MAX));
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter register and instruction-fetch sequencer. Issues one memory
// read per instruction, holds the returned word for decode, and loads NextPC
// when decode accepts it. A missing response faults after WAIT_TIMEOUT cycles.
// Parameters:
//   PC_RESET     - CurrentPC value after reset
//   WAIT_TIMEOUT - WAIT cycles before faulting (0 disables the timeout)
// Ports:
//   CLK, Reset   - clock, asynchronous active-high reset
//   bus (master) - memory request/response, decode handshake, NextPC, status
// Build option: PC_FETCH_ALIGN_CHECK_EN - fault on a misaligned NextPC
//   instead of silently clearing its low two bits.
// ----------------------------------------------------------------------------
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] PC_RESET     = 64'h0,
  parameter int unsigned         WAIT_TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            Reset,
  pc_fetch_unit_if.master bus
);

  localparam int unsigned TMO_W   = (WAIT_TIMEOUT < 32'd2) ? 32'd1
                                    : 32'($clog2(WAIT_TIMEOUT));
  // Fault fires when a WAIT cycle starts with the count at WAIT_TIMEOUT-1.
  localparam int unsigned TMO_MAX = (WAIT_TIMEOUT == 32'd0) ? 32'd0
                                    : WAIT_TIMEOUT - 32'd1;
  localparam bit          TMO_EN  = (WAIT_TIMEOUT != 32'd0);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   req_valid_q, instr_valid_q, fault_q;
  logic                   tmo_clr, tmo_en, tmo_tc;

  fetch_timeout_ctr #(
    .W   (TMO_W),
    .MAX (TMO_MAX)
  ) u_tmo (
    .clk   (CLK),
    .rst   (Reset),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (bus.IMemReqReady) begin
          state_d = ST_WAIT;
          tmo_clr = 1'b1;
        end
      end

      ST_WAIT: begin
        if (bus.IMemRspValid) begin
          instr_d = bus.IMemRspData;
          state_d = ST_DELIVER;
        end else begin
          tmo_en = 1'b1;
          if (TMO_EN && tmo_tc) begin
            state_d = ST_FAULT;
          end
        end
      end

      ST_DELIVER: begin
        if (bus.InstrReady) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef PC_FETCH_ALIGN_CHECK_EN
          pc_d    = bus.NextPC;
          state_d = pc_misaligned(bus.NextPC) ? ST_FAULT : ST_FETCH;
`else
          pc_d    = bus.NextPC & PC_ALIGN_MASK;
          state_d = ST_FETCH;
`endif
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // State register; valids are registered from the next state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= PC_RESET;
      instr_q       <= '0;
      cnt_q         <= '0;
      req_valid_q   <= 1'b1;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      cnt_q         <= cnt_d;
      req_valid_q   <= (state_d == ST_FETCH);
      instr_valid_q <= (state_d == ST_DELIVER);
      fault_q       <= (state_d == ST_FAULT);
    end
  end

  assign bus.IMemReqValid = req_valid_q;
  assign bus.IMemAddr     = pc_q;
  assign bus.InstrValid   = instr_valid_q;
  assign bus.Instr        = instr_q;
  assign bus.CurrentPC    = pc_q;
  assign bus.FetchFault   = fault_q;
  assign bus.InstrCount   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit (PC_RESET = 0x100, WAIT_TIMEOUT = 4).
// The bench plays instruction memory, decode and next-PC logic; expectations
// come from a simple model PC / instruction count kept here.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  localparam logic [63:0] PCR = 64'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .PC_RESET     (PCR),
    .WAIT_TIMEOUT (4)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.IMemReqReady = 1'b0;
    bus.IMemRspValid = 1'b0;
    bus.IMemRspData  = '0;
    bus.InstrReady   = 1'b0;
    bus.NextPC       = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full instruction: optional request/response/decode stalls with
  // stray response traffic outside WAIT. ok=0 if a handshake never came.
  task automatic do_fetch(input logic [31:0] data, input int req_dly,
                          input int rsp_dly, input int dec_dly,
                          input logic [63:0] next, output bit ok,
                          output logic [63:0] addr, output logic [31:0] seen,
                          output int acc_cyc);
    int budget;
    budget = 0;
    ok = 1'b0; addr = '0; seen = '0; acc_cyc = 0;
    while (bus.IMemReqValid !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    if (bus.IMemReqValid !== 1'b1) return;
    for (int i = 0; i < req_dly; i++) begin
      bus.IMemRspValid = 1'($urandom_range(0, 1));
      bus.IMemRspData  = $urandom;
      tick();
    end
    bus.IMemRspValid = 1'b0;
    addr = bus.IMemAddr;
    acc_cyc = cyc;
    bus.IMemReqReady = 1'b1;
    tick();
    bus.IMemReqReady = 1'b0;
    repeat (rsp_dly) tick();
    bus.IMemRspValid = 1'b1;
    bus.IMemRspData  = data;
    tick();
    bus.IMemRspValid = 1'b0;
    if (bus.InstrValid !== 1'b1) return;
    seen = bus.Instr;
    for (int i = 0; i < dec_dly; i++) begin
      bus.IMemRspValid = 1'($urandom_range(0, 1));
      bus.IMemRspData  = $urandom;
      tick();
    end
    bus.IMemRspValid = 1'b0;
    bus.InstrReady = 1'b1;
    bus.NextPC     = next;
    tick();
    bus.InstrReady = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    logic [63:0] mpc, addr;
    logic [31:0] data, seen;
    bit ok;
    int acc, prev_acc;
    idle_inputs();
    rst = 1'b1;
    tick();
    n_checks++; if (bus.CurrentPC !== PCR) begin n_fail++; $display("FAIL reset_pc got %h exp %h", bus.CurrentPC, PCR); end
    n_checks++; if (bus.IMemAddr !== PCR) begin n_fail++; $display("FAIL reset_addr got %h exp %h", bus.IMemAddr, PCR); end
    n_checks++; if (bus.Instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", bus.Instr); end
    n_checks++; if (bus.InstrCount !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.InstrCount); end
    n_checks++; if (bus.FetchFault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b exp 0", bus.FetchFault); end
    n_checks++; if (bus.InstrValid !== 1'b0) begin n_fail++; $display("FAIL reset_ivalid got %b exp 0", bus.InstrValid); end
    tick();
    rst = 1'b0;
    n_checks++; if (bus.IMemReqValid !== 1'b1) begin n_fail++; $display("FAIL reset_reqvalid got %b exp 1", bus.IMemReqValid); end
    mpc = PCR;
    prev_acc = 0;
    for (int i = 0; i < 3; i++) begin
      data = $urandom;
      do_fetch(data, 0, 0, 0, mpc + 64'd4, ok, addr, seen, acc);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL seq_handshake[%0d] got %b exp 1", i, ok); end
      n_checks++; if (addr !== mpc) begin n_fail++; $display("FAIL seq_addr[%0d] got %h exp %h", i, addr, mpc); end
      n_checks++; if (seen !== data) begin n_fail++; $display("FAIL seq_instr[%0d] got %h exp %h", i, seen, data); end
      if (i > 0) begin
        n_checks++; if (acc - prev_acc !== 3) begin n_fail++; $display("FAIL seq_cycles[%0d] got %0d exp 3", i, acc - prev_acc); end
      end
      prev_acc = acc;
      mpc = mpc + 64'd4;
    end
    n_checks++; if (bus.InstrCount !== 32'd3) begin n_fail++; $display("FAIL seq_count got %0d exp 3", bus.InstrCount); end
  endtask

  task automatic test_backpressure();
    localparam logic [31:0] NOP = 32'hD503201F;
    apply_reset();
    bus.IMemReqReady = 1'b1;
    tick();
    bus.IMemReqReady = 1'b0;
    bus.IMemRspValid = 1'b1;
    bus.IMemRspData  = NOP;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.IMemRspValid = 1'($urandom_range(0, 1));
      bus.IMemRspData  = $urandom;
      n_checks++; if (bus.InstrValid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, bus.InstrValid); end
      n_checks++; if (bus.Instr !== NOP) begin n_fail++; $display("FAIL bp_instr[%0d] got %h exp %h", i, bus.Instr, NOP); end
      n_checks++; if (bus.CurrentPC !== PCR) begin n_fail++; $display("FAIL bp_pc[%0d] got %h exp %h", i, bus.CurrentPC, PCR); end
      n_checks++; if (bus.InstrCount !== 32'd0) begin n_fail++; $display("FAIL bp_count[%0d] got %0d exp 0", i, bus.InstrCount); end
      tick();
    end
    bus.IMemRspValid = 1'b0;
    bus.InstrReady = 1'b1;
    bus.NextPC     = PCR + 64'd4;
    tick();
    bus.InstrReady = 1'b0;
    n_checks++; if (bus.CurrentPC !== PCR + 64'd4) begin n_fail++; $display("FAIL bp_pc_after got %h exp %h", bus.CurrentPC, PCR + 64'd4); end
    n_checks++; if (bus.InstrCount !== 32'd1) begin n_fail++; $display("FAIL bp_count_after got %0d exp 1", bus.InstrCount); end
    n_checks++; if (bus.InstrValid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after got %b exp 0", bus.InstrValid); end
    n_checks++; if (bus.IMemReqValid !== 1'b1) begin n_fail++; $display("FAIL bp_req_after got %b exp 1", bus.IMemReqValid); end
  endtask

  task automatic test_branch();
    logic [63:0] addr;
    logic [31:0] seen;
    bit ok;
    int acc;
    apply_reset();
    do_fetch($urandom, 0, 0, 0, 64'h104, ok, addr, seen, acc);
    do_fetch($urandom, 0, 0, 0, 64'h108, ok, addr, seen, acc);
    do_fetch($urandom, 0, 0, 0, 64'h40, ok, addr, seen, acc);
    n_checks++; if (addr !== 64'h108) begin n_fail++; $display("FAIL br_src_addr got %h exp 108", addr); end
    n_checks++; if (bus.IMemReqValid !== 1'b1 || bus.IMemAddr !== 64'h40) begin n_fail++; $display("FAIL br_target got v=%b a=%h exp v=1 a=40", bus.IMemReqValid, bus.IMemAddr); end
    do_fetch($urandom, 0, 0, 0, 64'h44, ok, addr, seen, acc);
    n_checks++; if (ok !== 1'b1 || addr !== 64'h40) begin n_fail++; $display("FAIL br_fetch got ok=%b a=%h exp ok=1 a=40", ok, addr); end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.IMemReqReady = 1'b1;
    tick();
    bus.IMemReqReady = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (bus.FetchFault !== 1'b0) begin n_fail++; $display("FAIL tmo_early[%0d] got %b exp 0", k, bus.FetchFault); end
    end
    tick();
    n_checks++; if (bus.FetchFault !== 1'b1) begin n_fail++; $display("FAIL tmo_fault got %b exp 1", bus.FetchFault); end
    bus.IMemRspValid = 1'b1;
    bus.IMemRspData  = 32'h1234_5678;
    bus.InstrReady   = 1'b1;
    bus.NextPC       = 64'h200;
    tick();
    tick();
    idle_inputs();
    n_checks++; if (bus.InstrValid !== 1'b0) begin n_fail++; $display("FAIL tmo_ivalid got %b exp 0", bus.InstrValid); end
    n_checks++; if (bus.IMemReqValid !== 1'b0) begin n_fail++; $display("FAIL tmo_reqvalid got %b exp 0", bus.IMemReqValid); end
    n_checks++; if (bus.FetchFault !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %b exp 1", bus.FetchFault); end
    n_checks++; if (bus.CurrentPC !== PCR) begin n_fail++; $display("FAIL tmo_pc got %h exp %h", bus.CurrentPC, PCR); end
  endtask

  task automatic test_misaligned();
    logic [63:0] addr;
    logic [31:0] seen;
    bit ok;
    int acc;
    apply_reset();
    do_fetch($urandom, 0, 0, 0, 64'h102, ok, addr, seen, acc);
    n_checks++; if (bus.InstrCount !== 32'd1) begin n_fail++; $display("FAIL mis_count got %0d exp 1", bus.InstrCount); end
`ifdef PC_FETCH_ALIGN_CHECK_EN
    n_checks++; if (bus.FetchFault !== 1'b1) begin n_fail++; $display("FAIL mis_fault got %b exp 1", bus.FetchFault); end
    n_checks++; if (bus.CurrentPC !== 64'h102) begin n_fail++; $display("FAIL mis_pc got %h exp 102", bus.CurrentPC); end
    n_checks++; if (bus.IMemReqValid !== 1'b0) begin n_fail++; $display("FAIL mis_req got %b exp 0", bus.IMemReqValid); end
`else
    n_checks++; if (bus.FetchFault !== 1'b0) begin n_fail++; $display("FAIL mis_fault got %b exp 0", bus.FetchFault); end
    n_checks++; if (bus.IMemAddr !== 64'h100) begin n_fail++; $display("FAIL mis_addr got %h exp 100", bus.IMemAddr); end
    n_checks++; if (bus.IMemReqValid !== 1'b1) begin n_fail++; $display("FAIL mis_req got %b exp 1", bus.IMemReqValid); end
`endif
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] addr;
    logic [31:0] seen, data;
    bit ok;
    int acc;
    apply_reset();
    do_fetch($urandom, 0, 0, 0, 64'h200, ok, addr, seen, acc);
    bus.IMemReqReady = 1'b1;
    tick();
    bus.IMemReqReady = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.IMemAddr !== PCR) begin n_fail++; $display("FAIL rw_async_addr got %h exp %h", bus.IMemAddr, PCR); end
    tick();
    rst = 1'b0;
    bus.IMemRspValid = 1'b1;
    bus.IMemRspData  = 32'hDEAD_BEEF;
    tick();
    bus.IMemRspValid = 1'b0;
    n_checks++; if (bus.InstrValid !== 1'b0) begin n_fail++; $display("FAIL rw_ivalid got %b exp 0", bus.InstrValid); end
    n_checks++; if (bus.IMemReqValid !== 1'b1) begin n_fail++; $display("FAIL rw_req got %b exp 1", bus.IMemReqValid); end
    n_checks++; if (bus.IMemAddr !== PCR) begin n_fail++; $display("FAIL rw_addr got %h exp %h", bus.IMemAddr, PCR); end
    n_checks++; if (bus.Instr !== 32'h0) begin n_fail++; $display("FAIL rw_instr got %h exp 0", bus.Instr); end
    data = $urandom;
    do_fetch(data, 0, 0, 0, PCR + 64'd4, ok, addr, seen, acc);
    n_checks++; if (ok !== 1'b1 || addr !== PCR || seen !== data) begin n_fail++; $display("FAIL rw_refetch got ok=%b a=%h i=%h exp ok=1 a=%h i=%h", ok, addr, seen, PCR, data); end
  endtask

  task automatic test_random();
    logic [63:0] mpc, next, addr;
    logic [31:0] data, seen;
    logic [31:0] mcnt;
    bit ok;
    int acc;
    apply_reset();
    mpc  = PCR;
    mcnt = 0;
    for (int i = 0; i < 40; i++) begin
      data = $urandom;
      if (i % 10 == 9) next = 64'hFFFF_FFFF_FFFF_FFFC;
      else next = {$urandom, $urandom} & ~64'h3;
      do_fetch(data, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), next, ok, addr, seen, acc);
      mcnt = mcnt + 32'd1;
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rnd_handshake[%0d] got %b exp 1", i, ok); end
      n_checks++; if (addr !== mpc) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, addr, mpc); end
      n_checks++; if (seen !== data) begin n_fail++; $display("FAIL rnd_instr[%0d] got %h exp %h", i, seen, data); end
      n_checks++; if (bus.InstrCount !== mcnt) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, bus.InstrCount, mcnt); end
      n_checks++; if (bus.CurrentPC !== next) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, bus.CurrentPC, next); end
      mpc = next;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_backpressure();
    test_branch();
    test_timeout();
    test_misaligned();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer. Holds `CurrentPC`, issues one instruction-memory read per instruction over a valid/ready request plus valid-only response channel, and presents the fetched word to decode with a valid/ready handshake. When decode accepts the instruction, the unit loads the `NextPC` value computed by the next-PC logic. It is the consumer side of the next-PC interface and sits between instruction memory and decode.

## Interface
- `PC_RESET`, 64'h0: value loaded into `CurrentPC` on reset.
- `WAIT_TIMEOUT`, 255: maximum cycles spent in WAIT before faulting. 0 disables the timeout.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `NextPC` input 64: next-PC value from the next-PC logic; sampled on the decode handshake.
- `IMemReqValid` output 1: fetch request valid.
- `IMemReqReady` input 1: instruction memory accepts the request.
- `IMemAddr` output 64: request address; always equals `CurrentPC`.
- `IMemRspValid` input 1: response data valid.
- `IMemRspData` input 32: instruction word.
- `InstrValid` output 1: `Instr` is valid for decode.
- `InstrReady` input 1: decode consumes `Instr`.
- `Instr` output 32: fetched instruction, held stable.
- `CurrentPC` output 64: address of `Instr` / the current fetch.
- `FetchFault` output 1: sticky fault flag.
- `InstrCount` output 32: count of instructions handed to decode; wraps modulo 2^32.

## Operation
- State machine states: FETCH, WAIT, DELIVER, FAULT. Reset state is FETCH.
- **FETCH**
  - `IMemReqValid` = 1.
  - On `IMemReqValid && IMemReqReady`: move to WAIT and clear the timeout counter.
- **WAIT**
  - On `IMemRspValid`: latch `IMemRspData` into `Instr` and move to DELIVER.
  - Otherwise increment the timeout counter.
  - If `WAIT_TIMEOUT != 0` and the counter reaches `WAIT_TIMEOUT`: move to FAULT.
- **DELIVER**
  - `InstrValid` = 1.
  - On `InstrReady`: `CurrentPC` <= `NextPC`, `InstrCount` += 1, move to FETCH.
- **FAULT**
  - `FetchFault` = 1. All valids are 0.
  - The unit stays in FAULT until reset.
- `IMemRspValid` outside WAIT is ignored. This covers stale responses after reset.
- `IMemAddr` and `Instr` are stable while their valid is high. `CurrentPC` changes only on the DELIVER handshake.
- All PC arithmetic is 64-bit unsigned and wraps modulo 2^64. `NextPC` = 64'hFFFF_FFFF_FFFF_FFFC is legal.

## Timing
- Reset values:
  - `CurrentPC` = `PC_RESET`; `IMemAddr` = `PC_RESET`.
  - `Instr` = 0, `InstrCount` = 0, `FetchFault` = 0, `InstrValid` = 0.
  - `IMemReqValid` = 1 in the first cycle after deassertion (state FETCH).
- Valid outputs are decoded from registered state only; there is no combinational path from any input to any valid.
- Minimum of 3 cycles per instruction with zero-wait memory:
  - request accepted in cycle N;
  - response in cycle N+1;
  - `InstrValid` in cycle N+2;
  - next request in cycle N+3 if `InstrReady` is high in N+2.
- Timeout: with no response, FAULT is entered on the edge ending the `WAIT_TIMEOUT`-th WAIT cycle.
- Reset asserted mid-transaction aborts immediately. A response already in flight is dropped.

## Configuration
- Macro: `PC_FETCH_ALIGN_CHECK_EN`.
- Defined: on the DELIVER handshake, if `NextPC[1:0] != 0`, `CurrentPC` still loads `NextPC` and the unit enters FAULT instead of FETCH. `InstrCount` still increments.
- Undefined: `NextPC[1:0]` is forced to 2'b00 when loading `CurrentPC`, and no fault is raised.

## Structure
- Shared package `cpu_pkg` holds:
  - the fetch state enum;
  - `PC_WIDTH` = 64 and `INSTR_WIDTH` = 32;
  - `PC_ALIGN_MASK`.
- One sub-module, `fetch_timeout_ctr`: a parameterised saturating counter with clear, enable and a terminal-count output.
- All remaining logic is flat in `pc_fetch_unit`.

## Test plan
- **Reset:** `PC_RESET` = 64'h100, zero-wait memory, `InstrReady` = 1, `NextPC` = `CurrentPC` + 4 → `IMemAddr` sequence 0x100, 0x104, 0x108, one instruction per 3 cycles; `InstrCount` = 3 after the third handshake.
- **Backpressure:** `InstrReady` held low for 5 cycles in DELIVER → `InstrValid` and `Instr` (0xD503201F) stay stable; `CurrentPC` is unchanged; `InstrCount` is unchanged.
- **Branch:** `NextPC` = 0x40 on the handshake at PC 0x108 → next `IMemAddr` = 0x40.
- **Timeout:** `WAIT_TIMEOUT` = 4, no response → `FetchFault` = 1 after 4 WAIT cycles; a later `IMemRspValid` is ignored; `InstrValid` stays 0.
- **Misaligned `NextPC` = 0x102:**
  - with `PC_FETCH_ALIGN_CHECK_EN` defined → `FetchFault` = 1 and `CurrentPC` = 0x102;
  - without it → next `IMemAddr` = 0x100 and no fault.
- **Reset in WAIT, then response the cycle after deassertion:** the response is dropped; `IMemAddr` = `PC_RESET`; `IMemReqValid` = 1.
